// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : serial_subtractor_if                                             |
// | Brief   : start/done handshake and operand/result bundle for the subtractor|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface serial_subtractor_if #(
    parameter int N = 16
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : serial_subtractor                                                |
// | Brief   : bit-serial a - b, LSB first, one full-subtractor cell + borrow   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_subtractor #(
    parameter int N = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int c_CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [N-1:0]         r_ra;
    logic [N-1:0]         r_rb;
    logic [N-2:0]         r_sr;      // upper N-1 bits of the partial difference
    logic                 r_bf;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_sa;
    logic                 r_sb;
    logic [N-1:0]         r_diff;
    logic                 r_borrow;
    logic                 r_ovf;
    logic                 r_zero;

    logic                 w_x;
    logic                 w_y;
    logic                 w_d;
    logic                 w_bnext;
    logic [N-1:0]         w_dnext;

    // Full-subtractor cell on the current LSB pair.
    assign w_x     = r_ra[0];
    assign w_y     = r_rb[0];
    assign w_d     = w_x ^ w_y ^ r_bf;
    assign w_bnext = (~w_x & w_y) | (~(w_x ^ w_y) & r_bf);
    assign w_dnext = {w_d, r_sr};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = SHIFT;
            SHIFT:   if (r_count == c_LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra     <= '0;
            r_rb     <= '0;
            r_sr     <= '0;
            r_bf     <= 1'b0;
            r_count  <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_ra    <= bus.a;
                        r_rb    <= bus.b;
                        r_sa    <= bus.a[N-1];
                        r_sb    <= bus.b[N-1];
                        r_bf    <= 1'b0;
                        r_count <= '0;
                    end
                end
                SHIFT: begin
                    r_ra    <= {1'b0, r_ra[N-1:1]};
                    r_rb    <= {1'b0, r_rb[N-1:1]};
                    r_sr    <= w_dnext[N-1:1];
                    r_bf    <= w_bnext;
                    r_count <= r_count + c_CNT_W'(1);
                    // Published results change only on the final bit, so they
                    // stay stable while the next operation shifts.
                    if (r_count == c_LAST) begin
                        r_diff   <= w_dnext;
                        r_borrow <= w_bnext;
                        r_ovf    <= (r_sa != r_sb) && (w_d != r_sa);
                        r_zero   <= (w_dnext == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state == SHIFT);
    assign bus.done     = (r_state == DONE);
    assign bus.diff     = r_diff;
    assign bus.borrow   = r_borrow;
    assign bus.overflow = r_ovf;
    assign bus.zero     = r_zero;
endmodule
`default_nettype wire
